imem_fetch_unit: RTL and testbench
==================================

Name: imem_fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the MIPS core decode/execute.
- Owns the fetch PC and issues one-outstanding req/ack reads to instruction memory.
- Buffers returned words with their PCs in a small FIFO and hands them to the core over a valid/ready handshake.
- Branch and jump redirects from the core flush the buffer and restart fetch.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, minimum 2).
- RESET_PC, 32'h00000000, fetch PC loaded at reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous active-low reset; reset==0 at posedge clears all state.
- mem_req  output  1  read request to instruction memory.
- mem_addr  output  32  word-aligned read address; stable while mem_req=1.
- mem_ack  input  1  one-cycle acknowledge; mem_rdata valid in the same cycle.
- mem_rdata  input  32  instruction word.
- inst_valid  output  1  head FIFO entry is available.
- inst_data  output  32  head instruction word.
- inst_pc  output  32  PC of the head instruction.
- inst_ready  input  1  core accepts the head entry this cycle.
- redirect  input  1  one-cycle flush and restart request.
- redirect_pc  input  32  new fetch PC; bits [1:0] are ignored and forced to 00.

Behaviour:
- Reset values: mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, FIFO count=0, fpc=RESET_PC, state=IDLE.
- Reset asserted mid-request drops mem_req the next cycle; the memory tolerates an abandoned request.
- FSM IDLE: go to WAIT and assert mem_req with mem_addr=fpc when (count + outstanding) < DEPTH and redirect=0.
- FSM WAIT:
  - Hold mem_req and mem_addr until mem_ack.
  - On mem_ack: push {fpc, mem_rdata} and set fpc=fpc+4.
  - Then either issue the next request back-to-back (stay in WAIT, new address next cycle) if space remains, or go to IDLE.
- FSM DISCARD, entered on a redirect while in WAIT:
  - Keep mem_req high at the old address until mem_ack, then drop the returned word.
  - Next state is IDLE; the next request uses the redirected fpc.
- mem_req deasserts for at least one cycle after each ack only when going to IDLE. Otherwise it stays high with the updated address.
- Redirect:
  - Takes priority over a same-cycle push and pop.
  - The FIFO is emptied and fpc=redirect_pc; inst_valid=0 the next cycle.
  - A same-cycle mem_ack in WAIT is dropped, and the next state is IDLE (not DISCARD).
  - A redirect in DISCARD only updates fpc.
- FIFO behaviour:
  - First-word-fallthrough: inst_valid = (count != 0); inst_data and inst_pc come from the head entry.
  - Pop occurs on inst_valid & inst_ready.
  - Latency: mem_ack at cycle N gives inst_valid=1 at N+1 when the FIFO was empty.
- Simultaneous push and pop: count unchanged, both applied.
- Overflow is impossible by the issue rule; pop on empty is ignored.
- fpc arithmetic is modulo 2^32: 32'hFFFFFFFC + 4 wraps to 32'h00000000.
- Pointers are log2(DEPTH) bits and wrap naturally.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds output perf_fetched (32-bit, counts pushes into the FIFO) and output perf_discarded (16-bit, counts words dropped in DISCARD or on redirect-with-ack).
  - Both counters clear on reset, saturate at all-ones, and are readable combinationally from their registers.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package fetch_pkg contains:
  - the FSM state type {IDLE, WAIT, DISCARD};
  - localparam PC_STEP = 4;
  - the default RESET_PC constant;
  - the FIFO entry struct {pc[31:0], instr[31:0]}.
- Sub-module fetch_fifo: synchronous FWFT FIFO, parameter DEPTH, with push, pop, flush, count, full and empty.
  - The top level holds the FSM, fpc and the issue rule.

Test Plan:
- Reset release, memory acks 1 cycle after each req, inst_ready=1: mem_addr sequence 0x0, 0x4, 0x8; inst_pc follows 0x0, 0x4, 0x8 one cycle behind each ack.
- inst_ready=0, DEPTH=4: exactly 4 requests issued, then mem_req=0 and count=4. Raise inst_ready for 1 cycle: one pop and one new request at addr 0x10.
- Redirect to 0x40 while WAIT at addr 0x8, ack arrives 3 cycles later: the word is dropped, FIFO is empty, and the next mem_addr is 0x40. With FETCH_PERF_EN, perf_discarded=1.
- Redirect asserted in the same cycle as mem_ack and inst_ready=1 with count=2: count=0 next cycle, fpc=redirect_pc, state IDLE.
- redirect_pc=0xFFFFFFFE: mem_addr=0xFFFFFFFC, and the following request is at 0x00000000.
- reset=0 mid-WAIT: next cycle mem_req=0, inst_valid=0, mem_addr=RESET_PC; fetch resumes from RESET_PC after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch unit.
//   fetch_state_e    : fetch FSM states (IDLE, WAIT, DISCARD)
//   PC_STEP          : byte increment between consecutive instruction words
//   DEFAULT_RESET_PC : default fetch PC after reset
//   fetch_entry_t    : one buffered instruction together with its PC
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous first-word-fallthrough FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk      : clock, all state changes on posedge
//   reset    : synchronous active-low reset
//   push_i   : write data_i this cycle
//   pop_i    : drop the head entry this cycle (ignored when empty)
//   flush_i  : empty the FIFO; wins over push and pop
//   data_i   : entry to write
//   data_o   : head entry (all zeros while empty)
//   count_o  : number of stored entries (0..DEPTH)
//   full_o   : count_o == DEPTH
//   empty_o  : count_o == 0
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  fetch_entry_t           data_i,
  output fetch_entry_t           data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pushFire;
  logic          popFire;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  // Gating the head keeps the outputs at zero when nothing valid is stored.
  assign data_o  = empty_o ? '0 : mem_q[rdPtr_q];

  // Next-state for pointers and occupancy; a push into a full FIFO is only
  // allowed when a pop frees the head in the same cycle.
  always_comb begin
    popFire  = pop_i & ~empty_o;
    pushFire = push_i & (~full_o | popFire);
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    count_d  = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (pushFire) wrPtr_d = wrPtr_q + PW'(1);
      if (popFire)  rdPtr_d = rdPtr_q + PW'(1);
      case ({pushFire, popFire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents need no reset because the head is gated by empty.
  always_ff @(posedge clk) begin
    if (pushFire && !flush_i) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// -----------------------------------------------------------------------------
// imem_fetch_unit
// Instruction fetch stage: owns the fetch PC, issues one-outstanding reads to
// instruction memory and buffers returned words for the core.
// Ports:
//   clk, reset         : clock and synchronous active-low reset
//   mem_req, mem_addr  : memory read request and word-aligned address
//   mem_ack, mem_rdata : one-cycle acknowledge with the returned word
//   inst_valid/data/pc : head of the instruction buffer towards the core
//   inst_ready         : core consumes the head entry
//   redirect(_pc)      : flush the buffer and restart fetch at a new PC
//   perf_fetched       : (FETCH_PERF_EN only) words pushed into the buffer
//   perf_discarded     : (FETCH_PERF_EN only) returned words thrown away
// Build option: define FETCH_PERF_EN to add the saturating perf counters.
// -----------------------------------------------------------------------------
module imem_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [15:0] perf_discarded
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LastFreeCount = CW'(DEPTH - 1);

  fetch_state_e  state_q;
  logic [31:0]   fpc_q;
  logic          memReq_q;
  logic [31:0]   memAddr_q;

  logic          pushFire;
  logic          popFire;
  logic          keepFetching;
  logic [31:0]   redirectAligned;
  logic [CW-1:0] fifoCount;
  logic          fifoFull;
  logic          fifoEmpty;
  fetch_entry_t  fifoHead;
  fetch_entry_t  fifoIn;
  logic          unusedPcBits;

  assign unusedPcBits    = ^redirect_pc[1:0];
  assign redirectAligned = {redirect_pc[31:2], 2'b00};

  // Buffer handshake. A redirect empties the buffer, so a word returning in
  // the same cycle is never pushed.
  always_comb begin
    pushFire     = (state_q == WAIT) & mem_ack & ~redirect;
    popFire      = ~fifoEmpty & inst_ready;
    fifoIn.pc    = fpc_q;
    fifoIn.instr = mem_rdata;
    // With this request retiring, outstanding drops to zero, so the next
    // request is legal whenever the post-push occupancy stays below DEPTH.
    keepFetching = popFire | (fifoCount < LastFreeCount);
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (pushFire),
    .pop_i   (popFire),
    .flush_i (redirect),
    .data_i  (fifoIn),
    .data_o  (fifoHead),
    .count_o (fifoCount),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // Fetch FSM with registered memory request outputs. fpc tracks the address
  // of the outstanding request in WAIT and the next address otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      fpc_q     <= RESET_PC;
      memReq_q  <= 1'b0;
      memAddr_q <= RESET_PC;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect) begin
            fpc_q <= redirectAligned;
          end else if (!fifoFull) begin
            state_q   <= WAIT;
            memReq_q  <= 1'b1;
            memAddr_q <= fpc_q;
          end
        end
        WAIT: begin
          if (redirect) begin
            fpc_q <= redirectAligned;
            if (mem_ack) begin
              state_q  <= IDLE;
              memReq_q <= 1'b0;
            end else begin
              state_q <= DISCARD;
            end
          end else if (mem_ack) begin
            fpc_q <= fpc_q + PC_STEP;
            if (keepFetching) begin
              memAddr_q <= fpc_q + PC_STEP;
            end else begin
              state_q  <= IDLE;
              memReq_q <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (redirect) fpc_q <= redirectAligned;
          if (mem_ack) begin
            state_q  <= IDLE;
            memReq_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          memReq_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req    = memReq_q;
  assign mem_addr   = memAddr_q;
  assign inst_valid = ~fifoEmpty;
  assign inst_data  = fifoHead.instr;
  assign inst_pc    = fifoHead.pc;

`ifdef FETCH_PERF_EN
  logic        dropFire;
  logic [31:0] perfFetched_q;
  logic [15:0] perfDiscarded_q;

  assign dropFire = mem_ack & ((state_q == DISCARD) | ((state_q == WAIT) & redirect));

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perfFetched_q   <= '0;
      perfDiscarded_q <= '0;
    end else begin
      if (pushFire && (perfFetched_q != '1))   perfFetched_q   <= perfFetched_q + 32'd1;
      if (dropFire && (perfDiscarded_q != '1)) perfDiscarded_q <= perfDiscarded_q + 16'd1;
    end
  end

  assign perf_fetched   = perfFetched_q;
  assign perf_discarded = perfDiscarded_q;
`endif

endmodule

// File: tb/tb_imem_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_unit
// Directed bench for imem_fetch_unit with a behavioural instruction memory and
// a scoreboard of expected {pc, instr} entries. Build with FETCH_PERF_EN to
// also exercise the perf counters.
// -----------------------------------------------------------------------------
module tb_imem_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [15:0] perf_discarded;
`endif

  int           testsRun;
  int           failCount;
  fetch_entry_t expQ[$];
  logic [31:0]  expFetchPc;
  bit           discardPending;
  bit           memEnable;
  int           waitCnt;
  int           acceptedAcks;

  always #5 clk = ~clk;

  imem_fetch_unit #(
    .DEPTH    (4),
    .RESET_PC (ResetPc)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .inst_valid  (inst_valid),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_discarded (perf_discarded)
`endif
  );

  // Contents of the behavioural instruction memory.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return {addr[15:0], ~addr[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Predict the effect of the coming edge from the inputs now driven, advance
  // one clock, then let the memory model decide whether to ack next cycle.
  task automatic applyStimulus();
    fetch_entry_t head;
    if (!reset) begin
      expQ.delete();
      expFetchPc     = ResetPc;
      discardPending = 1'b0;
      acceptedAcks   = 0;
    end else begin
      if (inst_valid && inst_ready && !redirect) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_valid", {31'b0, inst_valid}, 32'd0);
        end else begin
          head = expQ.pop_front();
          checkOutput("head_pc", inst_pc, head.pc);
          checkOutput("head_data", inst_data, head.instr);
        end
      end
      if (mem_ack) begin
        if (redirect || discardPending) begin
          discardPending = 1'b0;
        end else begin
          checkOutput("ack_addr", mem_addr, expFetchPc);
          expQ.push_back('{pc: expFetchPc, instr: mem_rdata});
          expFetchPc   = expFetchPc + 32'd4;
          acceptedAcks++;
        end
      end else if (redirect && mem_req) begin
        discardPending = 1'b1;
      end
      if (redirect) begin
        expQ.delete();
        expFetchPc = {redirect_pc[31:2], 2'b00};
      end
    end
    @(posedge clk);
    #1;
    if (mem_ack) waitCnt = 0;
    mem_ack = 1'b0;
    if (mem_req && memEnable) begin
      waitCnt++;
      if (waitCnt >= 1) begin
        mem_ack   = 1'b1;
        mem_rdata = memWord(mem_addr);
      end
    end else begin
      waitCnt = 0;
    end
  endtask

  task automatic waitForAddr(input logic [31:0] target, input int maxCycles);
    int n = 0;
    while (!(mem_req === 1'b1 && mem_addr === target) && n < maxCycles) begin
      applyStimulus();
      n++;
    end
    checkOutput("reach_addr", mem_addr, target);
  endtask

  task automatic pulseReset();
    reset = 1'b0;
    applyStimulus();
    reset = 1'b1;
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    testsRun       = 0;
    failCount      = 0;
    waitCnt        = 0;
    acceptedAcks   = 0;
    discardPending = 1'b0;
    memEnable      = 1'b0;
    expFetchPc     = ResetPc;
    reset          = 1'b0;
    mem_ack        = 1'b0;
    mem_rdata      = 32'h0;
    inst_ready     = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;

    // Reset values.
    applyStimulus();
    applyStimulus();
    checkOutput("rst_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, ResetPc);
    checkOutput("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("rst_inst_data", inst_data, 32'd0);
    checkOutput("rst_inst_pc", inst_pc, 32'd0);

    // Streaming fetch with single-cycle memory and a ready core.
    reset      = 1'b1;
    inst_ready = 1'b1;
    memEnable  = 1'b1;
    applyStimulus();
    checkOutput("s1_req", {31'b0, mem_req}, 32'd1);
    checkOutput("s1_addr0", mem_addr, 32'h0);
    applyStimulus();
    checkOutput("s1_addr4", mem_addr, 32'h4);
    checkOutput("s1_valid", {31'b0, inst_valid}, 32'd1);
    checkOutput("s1_pc0", inst_pc, 32'h0);
    applyStimulus();
    checkOutput("s1_addr8", mem_addr, 32'h8);
    checkOutput("s1_pc4", inst_pc, 32'h4);
    applyStimulus();
    checkOutput("s1_pc8", inst_pc, 32'h8);

    // Core stalled: exactly DEPTH requests, then fetch pauses.
    pulseReset();
    inst_ready = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus();
    checkOutput("s2_acks", 32'(acceptedAcks), 32'd4);
    checkOutput("s2_req_idle", {31'b0, mem_req}, 32'd0);
    checkOutput("s2_model_count", 32'(expQ.size()), 32'd4);
    checkOutput("s2_head_pc", inst_pc, 32'h0);
    memEnable  = 1'b0;
    inst_ready = 1'b1;
    applyStimulus();
    inst_ready = 1'b0;
    checkOutput("s2_req_after_pop", {31'b0, mem_req}, 32'd0);
    applyStimulus();
    checkOutput("s2_req_resume", {31'b0, mem_req}, 32'd1);
    checkOutput("s2_addr_resume", mem_addr, 32'h10);
    checkOutput("s2_head_pc4", inst_pc, 32'h4);

    // Redirect while waiting on address 0x8; the late ack is discarded.
    pulseReset();
    inst_ready = 1'b1;
    memEnable  = 1'b1;
    waitForAddr(32'h8, 10);
    mem_ack     = 1'b0;
    memEnable   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    applyStimulus();
    redirect = 1'b0;
    checkOutput("s3_valid_flushed", {31'b0, inst_valid}, 32'd0);
    checkOutput("s3_req_held", {31'b0, mem_req}, 32'd1);
    checkOutput("s3_addr_held", mem_addr, 32'h8);
    applyStimulus();
    applyStimulus();
    checkOutput("s3_addr_still", mem_addr, 32'h8);
    mem_ack   = 1'b1;
    mem_rdata = memWord(32'h8);
    applyStimulus();
    checkOutput("s3_req_drop", {31'b0, mem_req}, 32'd0);
    checkOutput("s3_valid_empty", {31'b0, inst_valid}, 32'd0);
`ifdef FETCH_PERF_EN
    checkOutput("s3_perf_discarded", {16'b0, perf_discarded}, 32'd1);
    checkOutput("s3_perf_fetched", perf_fetched, 32'd2);
`endif
    memEnable = 1'b1;
    applyStimulus();
    checkOutput("s3_addr_redirect", mem_addr, 32'h40);
    applyStimulus();
    applyStimulus();

    // Redirect colliding with an ack and a pop while two entries are buffered.
    pulseReset();
    inst_ready = 1'b0;
    waitForAddr(32'h8, 10);
    checkOutput("s4_model_count", 32'(expQ.size()), 32'd2);
    checkOutput("s4_head_pc", inst_pc, 32'h0);
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    applyStimulus();
    redirect = 1'b0;
    checkOutput("s4_valid_flushed", {31'b0, inst_valid}, 32'd0);
    checkOutput("s4_req_idle", {31'b0, mem_req}, 32'd0);
`ifdef FETCH_PERF_EN
    checkOutput("s4_perf_discarded", {16'b0, perf_discarded}, 32'd1);
`endif
    applyStimulus();
    checkOutput("s4_addr_redirect", mem_addr, 32'h100);
    for (int i = 0; i < 3; i++) applyStimulus();

    // Unaligned redirect near the top of the address space, then wrap.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    applyStimulus();
    redirect = 1'b0;
    applyStimulus();
    checkOutput("s5_addr_top", mem_addr, 32'hFFFF_FFFC);
    applyStimulus();
    checkOutput("s5_addr_wrap", mem_addr, 32'h0);
    checkOutput("s5_pc_top", inst_pc, 32'hFFFF_FFFC);

    // Reset asserted while a request is outstanding.
    applyStimulus();
    mem_ack   = 1'b0;
    memEnable = 1'b0;
    checkOutput("s6_addr_before", mem_addr, 32'h4);
    reset = 1'b0;
    applyStimulus();
    checkOutput("s6_req_reset", {31'b0, mem_req}, 32'd0);
    checkOutput("s6_valid_reset", {31'b0, inst_valid}, 32'd0);
    checkOutput("s6_addr_reset", mem_addr, ResetPc);
    reset     = 1'b1;
    memEnable = 1'b1;
    applyStimulus();
    checkOutput("s6_req_resume", {31'b0, mem_req}, 32'd1);
    checkOutput("s6_addr_resume", mem_addr, ResetPc);
    applyStimulus();
    checkOutput("s6_pc_resume", inst_pc, ResetPc);
    applyStimulus();
    applyStimulus();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
